// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: code-group constants, sub-block decode tables,
// code-group classes, receive state encodings and special octets.
package pcs_pkg;

    typedef enum logic [2:0] {
        CG_COMMA,
        CG_S,
        CG_T,
        CG_R,
        CG_V,
        CG_DATA,
        CG_INVALID
    } cg_class_e;

    typedef enum logic [2:0] {
        ST_LINK_FAILED,
        ST_WAIT_FOR_K,
        ST_RX_K,
        ST_IDLE_D,
        ST_RECEIVE,
        ST_TRI_RRI
    } rx_state_e;

    // Code groups are held as {abcdei, fghj}; _N / _P are the RD- / RD+ columns.
    localparam logic [9:0] CG_K28_5_N = 10'b0011111010;
    localparam logic [9:0] CG_K28_5_P = 10'b1100000101;
    localparam logic [9:0] CG_K27_7_N = 10'b1101101000;
    localparam logic [9:0] CG_K27_7_P = 10'b0010010111;
    localparam logic [9:0] CG_K29_7_N = 10'b1011101000;
    localparam logic [9:0] CG_K29_7_P = 10'b0100010111;
    localparam logic [9:0] CG_K23_7_N = 10'b1110101000;
    localparam logic [9:0] CG_K23_7_P = 10'b0001010111;
    localparam logic [9:0] CG_K30_7_N = 10'b0111101000;
    localparam logic [9:0] CG_K30_7_P = 10'b1000010111;
    localparam logic [9:0] CG_D16_2_N = 10'b0110110101;
    localparam logic [9:0] CG_D16_2_P = 10'b1001000101;
    localparam logic [9:0] CG_D5_6    = 10'b1010010110;

    localparam logic [7:0] OCT_PREAMBLE = 8'h55;
    localparam logic [7:0] OCT_ERROR    = 8'h0E;

    typedef struct packed {
        logic       ok;
        logic [4:0] val;
    } dec5_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] val;
    } dec3_t;

    // 5b/6b data table, both disparity columns.
    function automatic dec5_t dec_6b(input logic [5:0] c);
        dec5_t r;
        r.ok  = 1'b1;
        r.val = 5'd0;
        case (c)
            6'b100111, 6'b011000: r.val = 5'd0;
            6'b011101, 6'b100010: r.val = 5'd1;
            6'b101101, 6'b010010: r.val = 5'd2;
            6'b110001:            r.val = 5'd3;
            6'b110101, 6'b001010: r.val = 5'd4;
            6'b101001:            r.val = 5'd5;
            6'b011001:            r.val = 5'd6;
            6'b111000, 6'b000111: r.val = 5'd7;
            6'b111001, 6'b000110: r.val = 5'd8;
            6'b100101:            r.val = 5'd9;
            6'b010101:            r.val = 5'd10;
            6'b110100:            r.val = 5'd11;
            6'b001101:            r.val = 5'd12;
            6'b101100:            r.val = 5'd13;
            6'b011100:            r.val = 5'd14;
            6'b010111, 6'b101000: r.val = 5'd15;
            6'b011011, 6'b100100: r.val = 5'd16;
            6'b100011:            r.val = 5'd17;
            6'b010011:            r.val = 5'd18;
            6'b110010:            r.val = 5'd19;
            6'b001011:            r.val = 5'd20;
            6'b101010:            r.val = 5'd21;
            6'b011010:            r.val = 5'd22;
            6'b111010, 6'b000101: r.val = 5'd23;
            6'b110011, 6'b001100: r.val = 5'd24;
            6'b100110:            r.val = 5'd25;
            6'b010110:            r.val = 5'd26;
            6'b110110, 6'b001001: r.val = 5'd27;
            6'b001110:            r.val = 5'd28;
            6'b101110, 6'b010001: r.val = 5'd29;
            6'b011110, 6'b100001: r.val = 5'd30;
            6'b101011, 6'b010100: r.val = 5'd31;
            default:              r.ok  = 1'b0;
        endcase
        return r;
    endfunction

    // 3b/4b data table, both columns plus the alternate D.x.A7 forms.
    function automatic dec3_t dec_4b(input logic [3:0] c);
        dec3_t r;
        r.ok  = 1'b1;
        r.val = 3'd0;
        case (c)
            4'b1011, 4'b0100:                   r.val = 3'd0;
            4'b1001:                            r.val = 3'd1;
            4'b0101:                            r.val = 3'd2;
            4'b1100, 4'b0011:                   r.val = 3'd3;
            4'b1101, 4'b0010:                   r.val = 3'd4;
            4'b1010:                            r.val = 3'd5;
            4'b0110:                            r.val = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: r.val = 3'd7;
            default:                            r.ok  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcs_decode_10b8b.sv
// Combinational 10b/8b classifier: special code groups first, then data sub-blocks.
module pcs_decode_10b8b
    import pcs_pkg::*;
(
    input  logic [9:0] code_i,
    output cg_class_e  class_o,
    output logic [7:0] octet_o
);

    dec5_t lo;
    dec3_t hi;

    assign lo = dec_6b(code_i[9:4]);
    assign hi = dec_4b(code_i[3:0]);

    // Special groups are matched before data because K23/27/29/30 reuse data 6b sub-blocks.
    always_comb begin
        class_o = CG_INVALID;
        octet_o = '0;
        if (code_i == CG_K28_5_N || code_i == CG_K28_5_P) begin
            class_o = CG_COMMA;
        end else if (code_i == CG_K27_7_N || code_i == CG_K27_7_P) begin
            class_o = CG_S;
        end else if (code_i == CG_K29_7_N || code_i == CG_K29_7_P) begin
            class_o = CG_T;
        end else if (code_i == CG_K23_7_N || code_i == CG_K23_7_P) begin
            class_o = CG_R;
        end else if (code_i == CG_K30_7_N || code_i == CG_K30_7_P) begin
            class_o = CG_V;
        end else if (lo.ok && hi.ok) begin
            class_o = CG_DATA;
            octet_o = {hi.val, lo.val};
        end
    end

endmodule

// File: rtl/pcs_receive.sv
// PCS receive state machine: tracks idle/packet framing from decoded code groups
// and drives registered GMII receive outputs one cycle after each code group.
module pcs_receive
    import pcs_pkg::*;
(
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        code_sync_status,
    input  logic [10:0] SUDI,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);

    rx_state_e  state_q, state_d;
    logic [7:0] rxd_q, rxd_d;
    logic       dv_q, dv_d;
    logic       er_q, er_d;
    logic       recv_q, recv_d;

    cg_class_e  cls;
    logic [7:0] octet;
    logic       rx_even;

    assign rx_even = SUDI[10];

    pcs_decode_10b8b u_decode (
        .code_i  (SUDI[9:0]),
        .class_o (cls),
        .octet_o (octet)
    );

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= ST_LINK_FAILED;
            rxd_q   <= '0;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            recv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rxd_q   <= rxd_d;
            dv_q    <= dv_d;
            er_q    <= er_d;
            recv_q  <= recv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rxd_d   = '0;
        dv_d    = 1'b0;
        er_d    = 1'b0;
        recv_d  = 1'b0;
        if (!code_sync_status) begin
            state_d = ST_LINK_FAILED;
        end else begin
            case (state_q)
                ST_LINK_FAILED: state_d = ST_WAIT_FOR_K;
                ST_WAIT_FOR_K: begin
                    if (cls == CG_COMMA && rx_even) state_d = ST_RX_K;
                end
                ST_RX_K: begin
                    state_d = (cls == CG_DATA) ? ST_IDLE_D : ST_WAIT_FOR_K;
                end
                ST_IDLE_D: begin
                    if (cls == CG_COMMA) begin
                        state_d = ST_RX_K;
                    end else if (cls == CG_S) begin
                        state_d = ST_RECEIVE;
                        rxd_d   = OCT_PREAMBLE;
                        dv_d    = 1'b1;
                        recv_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end
                ST_RECEIVE: begin
                    case (cls)
                        CG_DATA: begin
                            rxd_d  = octet;
                            dv_d   = 1'b1;
                            recv_d = 1'b1;
                        end
                        CG_T: begin
                            state_d = ST_TRI_RRI;
                            recv_d  = 1'b1;
                        end
                        // Early end: flag the truncated frame for one cycle, drop carrier.
                        CG_COMMA: begin
                            state_d = ST_RX_K;
                            rxd_d   = OCT_ERROR;
                            dv_d    = 1'b1;
                            er_d    = 1'b1;
                        end
                        default: begin
                            rxd_d  = OCT_ERROR;
                            dv_d   = 1'b1;
                            er_d   = 1'b1;
                            recv_d = 1'b1;
                        end
                    endcase
                end
                ST_TRI_RRI: begin
                    if (cls == CG_R) begin
                        recv_d = 1'b1;
                    end else if (cls == CG_COMMA && rx_even) begin
                        state_d = ST_RX_K;
                    end else begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end
                default: state_d = ST_LINK_FAILED;
            endcase
        end
    end

    assign RXD       = rxd_q;
    assign RX_DV     = dv_q;
    assign RX_ER     = er_q;
    assign receiving = recv_q;

endmodule

// File: doc/pcs_receive.md
PCS_RECEIVE -- requirements
Module: pcs_receive

Interface
REQ-001 SHALL have ports: Clk  in  1  receive clock; all state changes on its rising edge.
REQ-002 SHALL have ports: mr_main_reset  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: code_sync_status  in  1  synchronizer lock indication (1 = synchronized).
REQ-004 SHALL have ports: SUDI  in  11  SUDI[10] = rx_even, SUDI[9:0] = received code group, as output by the synchronizer.
REQ-005 SHALL have ports: RXD  out  8  decoded octet to the GMII side.
REQ-006 SHALL have ports: RX_DV  out  1  receive data valid.
REQ-007 SHALL have ports: RX_ER  out  1  receive error.
REQ-008 SHALL have ports: receiving  out  1  packet reception in progress.

Function
REQ-009 SHALL sample SUDI every cycle; all outputs registered, valid the cycle after the code group is presented (latency 1).
REQ-010 SHALL classify each code group via the decoder as one of: COMMA (K28.5), /S/ (K27.7), /T/ (K29.7), /R/ (K23.7), /V/ (K30.7), DATA(octet), INVALID; both running-disparity columns accepted, disparity not checked.
REQ-011 SHALL implement states LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI.
REQ-012 LINK_FAILED: entered from any state whenever code_sync_status=0; RX_DV=0, RX_ER=0, receiving=0, RXD=0x00; exit to WAIT_FOR_K when code_sync_status=1.
REQ-013 WAIT_FOR_K: COMMA with rx_even=1 -> RX_K; otherwise stay; outputs as LINK_FAILED.
REQ-014 RX_K: DATA -> IDLE_D; anything else -> WAIT_FOR_K.
REQ-015 IDLE_D: COMMA -> RX_K; /S/ -> RECEIVE with RXD=0x55, RX_DV=1, RX_ER=0, receiving=1; other -> WAIT_FOR_K.
REQ-016 RECEIVE, DATA: RXD=octet, RX_DV=1, RX_ER=0.
REQ-017 RECEIVE, /T/: -> TRI_RRI; RX_DV=0, RX_ER=0, RXD=0x00.
REQ-018 RECEIVE, COMMA (early end): -> RX_K; RX_DV=1, RX_ER=1 for exactly that cycle, receiving=0.
REQ-019 RECEIVE, /V/ or INVALID: stay; RX_DV=1, RX_ER=1, RXD=0x0E; /S/ or /R/ treated likewise.
REQ-020 TRI_RRI: /R/ -> stay; COMMA with rx_even=1 -> RX_K, receiving=0; any other -> WAIT_FOR_K, receiving=0.
REQ-021 Outside RECEIVE and TRI_RRI, receiving SHALL be 0; RX_DV/RX_ER SHALL never be X after reset.
REQ-022 Simultaneous loss of sync and a code group: loss of sync wins, code group ignored.

Reset
REQ-023 mr_main_reset=0 SHALL immediately force state LINK_FAILED, RXD=0x00, RX_DV=0, RX_ER=0, receiving=0, regardless of Clk.
REQ-024 Reset asserted mid-packet SHALL drop RX_DV in the same cycle; no partial octet emitted after release.
REQ-025 After release, first state change SHALL occur on the next rising Clk edge.

Structure
REQ-026 Shared package SHALL hold the 10-bit code-group constants (COMMA, /S/, /T/, /R/, /V/, both disparities), the data octet table (minimum 0x00-0x0F, D5.6, D16.2), the state encodings, and the 0x55 / 0x0E octet constants; same package as the transmitter.
REQ-027 Decoding SHALL be a combinational sub-module pcs_decode_10b8b (code group in; class, octet out); the FSM and output registers live in pcs_receive.

Verification
REQ-028 Reset low 15 ns with sync=1 -> all outputs 0; after release, COMMA(even), D16.2 -> state IDLE_D, outputs still 0.
REQ-029 Idle then /S/, D0.0, D1.0, D2.0, /T/, /R/, COMMA -> RXD 0x55,0x00,0x01,0x02 with RX_DV=1, then RX_DV=0; receiving high from /S/ through /R/.
REQ-030 Mid-packet 10'b0000000000 -> exactly one cycle RX_DV=1, RX_ER=1, RXD=0x0E; following DATA decodes normally.
REQ-031 COMMA mid-packet -> one cycle RX_DV=1, RX_ER=1, then RX_DV=0, receiving=0, state RX_K.
REQ-032 code_sync_status dropped mid-packet -> RX_DV=0 next cycle; re-sync then COMMA(even), D5.6, /S/ -> new packet accepted.
REQ-033 mr_main_reset pulsed low between Clk edges mid-packet -> outputs clear before next edge; no RX_DV until a fresh /S/ after idle.
